// File: rtl/fila_pkg.sv
// Shared types and sizes for the Fila queue and its consumer-side drain controller.
package fila_pkg;

  localparam int FILA_DEPTH = 8;
  localparam int FILA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    GAP     = 3'd4
  } drain_state_t;

endpackage

// File: rtl/fila_gap_timer.sv
// 8-bit loadable down-counter that times the idle gap between presented words.
module fila_gap_timer (
  input  logic       clock_10khz,
  input  logic       reset_n,
  input  logic       load_in,
  input  logic [7:0] load_val_in,
  input  logic       dec_in,
  output logic       done_out
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_in) begin
      count_d = load_val_in;
    end else if (dec_in && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clock_10khz or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_out = (count_q == 8'd0);

endmodule

// File: rtl/fila_drain.sv
// Consumer-side drain for the Fila queue: dequeues one byte at a time and hands it off on valid/ready.
// FILA_DRAIN_COUNT_EN adds a saturating count of handed-off words on drained_count_out.
//
// state   | meaning
// IDLE    | waiting for enable_in and a non-empty queue
// REQ     | dequeue_out high for this single cycle
// WAIT    | queue updates data_in; captured into data_out on exit
// PRESENT | valid_out high, holding data_out until ready_in
// GAP     | minimum idle spacing after a handshake
module fila_drain
  import fila_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clock_10khz,
  input  logic                  reset_n,
  input  logic                  enable_in,
  input  logic [FILA_WIDTH-1:0] len_in,
  input  logic [FILA_WIDTH-1:0] data_in,
  output logic                  dequeue_out,
  output logic [FILA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy_out
`ifdef FILA_DRAIN_COUNT_EN
  ,
  output logic [7:0]            drained_count_out
`endif
);

  localparam logic [7:0] GAP_LOAD = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);

  drain_state_t          state_q, state_d;
  logic                  dequeue_q, dequeue_d;
  logic                  valid_q, valid_d;
  logic [FILA_WIDTH-1:0] data_q, data_d;
  logic                  gap_load;
  logic                  gap_dec;
  logic                  gap_done;

  always_comb begin
    state_d   = state_q;
    dequeue_d = 1'b0;
    valid_d   = valid_q;
    data_d    = data_q;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_in && (len_in != '0)) begin
          state_d   = REQ;
          dequeue_d = 1'b1;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d = PRESENT;
        valid_d = 1'b1;
        data_d  = data_in;
      end
      PRESENT: begin
        if (ready_in) begin
          valid_d = 1'b0;
          if (HOLD_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = GAP;
            gap_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_10khz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dequeue_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      dequeue_q <= dequeue_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  fila_gap_timer u_gap_timer (
    .clock_10khz (clock_10khz),
    .reset_n     (reset_n),
    .load_in     (gap_load),
    .load_val_in (GAP_LOAD),
    .dec_in      (gap_dec),
    .done_out    (gap_done)
  );

  assign dequeue_out = dequeue_q;
  assign valid_out   = valid_q;
  assign data_out    = data_q;
  assign busy_out    = (state_q != IDLE);

`ifdef FILA_DRAIN_COUNT_EN
  logic [7:0] count_q, count_d;
  logic       handshake;

  assign handshake = (state_q == PRESENT) && ready_in;

  always_comb begin
    count_d = count_q;
    if (handshake && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock_10khz or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign drained_count_out = count_q;
`endif

endmodule
